// File: rtl/proc_pkg.sv
`default_nettype none
// ============================================================================
// Module      : proc_pkg
// Description : Shared processor constants, fetch FSM state type.
// Revision    : 1.0 - initial release
// ============================================================================
package proc_pkg;

    localparam int unsigned ADDR_W   = 19;
    localparam int unsigned INSTR_W  = 32;
    localparam int unsigned RESET_PC = 0;
    localparam int unsigned IMM_W    = 28;

    localparam logic [INSTR_W-1:0] NOP_INSTR = '0;

    typedef enum logic [1:0] {
        BOOT   = 2'd0,
        RUN    = 2'd1,
        HALTED = 2'd2
    } fetch_state_t;

endpackage
`default_nettype wire

// File: rtl/pc_register.sv
`default_nettype none
// ============================================================================
// Module      : pc_register
// Description : Fetch PC register with next-PC priority mux and wrapping increment.
// Revision    : 1.0 - initial release
// ============================================================================
module pc_register
    import proc_pkg::*;
#(
    parameter int unsigned       ADDR_W   = proc_pkg::ADDR_W,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              redirect,
    input  logic              hold,
    input  logic [ADDR_W-1:0] branchTarget,
    output logic [ADDR_W-1:0] pcF,
    output logic [ADDR_W-1:0] nextPc
);

    logic [ADDR_W-1:0] r_pcF;
    logic [ADDR_W-1:0] w_nextPc;

    // The increment is width-limited so the all-ones address wraps to zero.
    always_comb begin
        w_nextPc = r_pcF + ADDR_W'(1);
        if (!rst_n) begin
            w_nextPc = RESET_PC;
        end else if (redirect) begin
            w_nextPc = branchTarget;
        end else if (hold) begin
            w_nextPc = r_pcF;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_pcF <= RESET_PC;
        end else begin
            r_pcF <= w_nextPc;
        end
    end

    assign pcF    = r_pcF;
    assign nextPc = w_nextPc;

endmodule
`default_nettype wire

// File: rtl/fetch_stage.sv
`default_nettype none
// ============================================================================
// Module      : fetch_stage
// Description : Instruction fetch with IF/ID register, stall/flush/branch/halt.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_stage
    import proc_pkg::*;
#(
    parameter int unsigned       ADDR_W   = proc_pkg::ADDR_W,
    parameter int unsigned       INSTR_W  = proc_pkg::INSTR_W,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(proc_pkg::RESET_PC)
) (
    input  logic               clk,
    input  logic               rst_n,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic [INSTR_W-1:0] imem_rdata,
    input  logic               stall_d,
    input  logic               flush_d,
    input  logic               branch_taken,
    input  logic [ADDR_W-1:0]  branch_target,
    input  logic               halt,
    output logic [INSTR_W-1:0] instr_d,
    output logic [IMM_W-1:0]   instr_imm_d,
    output logic [ADDR_W-1:0]  pc_d,
    output logic [ADDR_W-1:0]  pc_plus1_d,
    output logic               valid_d,
    output logic [31:0]        fetch_count
);

    fetch_state_t       r_state;
    fetch_state_t       w_stateNext;
    logic               w_redirect;
    logic               w_hold;
    logic               w_bubble;
    logic [ADDR_W-1:0]  w_pcF;
    logic [INSTR_W-1:0] r_instrD;
    logic [ADDR_W-1:0]  r_pcD;
    logic [ADDR_W-1:0]  r_pcPlus1D;
    logic               r_validD;
    logic [31:0]        r_fetchCount;

    // BOOT holds the PC so the reset-address word fetched during reset is the
    // first instruction loaded after the single boot bubble.
    assign w_redirect = branch_taken && (r_state == RUN);
    assign w_hold     = stall_d || halt || (r_state == HALTED) || (r_state == BOOT);
    assign w_bubble   = branch_taken || flush_d || (r_state == BOOT) || (r_state == HALTED);

    pc_register #(
        .ADDR_W   (ADDR_W),
        .RESET_PC (RESET_PC)
    ) u_pcRegister (
        .clk          (clk),
        .rst_n        (rst_n),
        .redirect     (w_redirect),
        .hold         (w_hold),
        .branchTarget (branch_target),
        .pcF          (w_pcF),
        .nextPc       (imem_addr)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= BOOT;
        end else begin
            r_state <= w_stateNext;
        end
    end

    always_comb begin
        w_stateNext = r_state;
        case (r_state)
            BOOT:    w_stateNext = RUN;
            RUN:     if (halt && !branch_taken) w_stateNext = HALTED;
            HALTED:  w_stateNext = HALTED;
            default: w_stateNext = BOOT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_validD     <= 1'b0;
            r_instrD     <= NOP_INSTR;
            r_pcD        <= '0;
            r_pcPlus1D   <= '0;
            r_fetchCount <= '0;
        end else if (w_bubble) begin
            r_validD <= 1'b0;
            r_instrD <= NOP_INSTR;
        end else if (!stall_d) begin
            r_validD     <= 1'b1;
            r_instrD     <= imem_rdata;
            r_pcD        <= w_pcF;
            r_pcPlus1D   <= w_pcF + ADDR_W'(1);
            r_fetchCount <= r_fetchCount + 32'd1;
        end
    end

    assign instr_d     = r_instrD;
    assign instr_imm_d = r_instrD[IMM_W-1:0];
    assign pc_d        = r_pcD;
    assign pc_plus1_d  = r_pcPlus1D;
    assign valid_d     = r_validD;
    assign fetch_count = r_fetchCount;

endmodule
`default_nettype wire

// File: tb/tb_fetch_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_fetch_stage
// Description : Scoreboard bench for fetch_stage with a registered ROM model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_stage;

    localparam int AW = 19;
    localparam int IW = 32;

    typedef struct {
        logic          valid;
        logic [AW-1:0] pc;
        logic [AW-1:0] pcPlus1;
        logic [31:0]   cnt;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          stall_d = 1'b0;
    logic          flush_d = 1'b0;
    logic          branch_taken = 1'b0;
    logic [AW-1:0] branch_target = '0;
    logic          halt = 1'b0;

    logic [AW-1:0] imemAddr, imemAddr2;
    logic [IW-1:0] imemRdata, imemRdata2;
    logic [IW-1:0] instrD, instrD2;
    logic [27:0]   instrImmD, instrImmD2;
    logic [AW-1:0] pcD, pcD2, pcPlus1D, pcPlus1D2;
    logic          validD, validD2;
    logic [31:0]   fetchCount, fetchCount2;

    exp_t sb[$];
    int   nTests = 0;
    int   nFails = 0;

    always #5 clk = ~clk;

    function automatic logic [IW-1:0] romWord(input logic [AW-1:0] a);
        return 32'hA000_0000 + {13'b0, a};
    endfunction

    always @(posedge clk) imemRdata  <= romWord(imemAddr);
    always @(posedge clk) imemRdata2 <= romWord(imemAddr2);

    fetch_stage #(.ADDR_W(AW), .INSTR_W(IW), .RESET_PC(19'h00000)) dut (
        .clk(clk), .rst_n(rst_n), .imem_addr(imemAddr), .imem_rdata(imemRdata),
        .stall_d(stall_d), .flush_d(flush_d), .branch_taken(branch_taken),
        .branch_target(branch_target), .halt(halt), .instr_d(instrD),
        .instr_imm_d(instrImmD), .pc_d(pcD), .pc_plus1_d(pcPlus1D),
        .valid_d(validD), .fetch_count(fetchCount)
    );

    fetch_stage #(.ADDR_W(AW), .INSTR_W(IW), .RESET_PC(19'h7FFFF)) dutWrap (
        .clk(clk), .rst_n(rst_n), .imem_addr(imemAddr2), .imem_rdata(imemRdata2),
        .stall_d(1'b0), .flush_d(1'b0), .branch_taken(1'b0),
        .branch_target(19'h00000), .halt(1'b0), .instr_d(instrD2),
        .instr_imm_d(instrImmD2), .pc_d(pcD2), .pc_plus1_d(pcPlus1D2),
        .valid_d(validD2), .fetch_count(fetchCount2)
    );

    task automatic checkVal(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        nTests++;
        if (obs !== exp) begin
            nFails++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input bit rn, input bit st, input bit fl, input bit br,
                         input logic [AW-1:0] tg, input bit hl, input bit ev,
                         input logic [AW-1:0] epc, input logic [AW-1:0] epp,
                         input logic [31:0] ecnt);
        @(negedge clk);
        rst_n         = rn;
        stall_d       = st;
        flush_d       = fl;
        branch_taken  = br;
        branch_target = tg;
        halt          = hl;
        sb.push_back('{ev, epc, epp, ecnt});
        #1;
    endtask

    task automatic settle(input string tag);
        exp_t          e;
        logic [IW-1:0] expInstr;
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            checkVal({tag, "/scoreboardEmpty"}, 64'd1, 64'd0);
        end else begin
            e = sb.pop_front();
            expInstr = e.valid ? romWord(e.pc) : 32'h0;
            checkVal({tag, "/valid"},   {63'b0, validD}, {63'b0, e.valid});
            checkVal({tag, "/instr"},   {32'b0, instrD}, {32'b0, expInstr});
            checkVal({tag, "/imm"},     {36'b0, instrImmD}, {36'b0, expInstr[27:0]});
            checkVal({tag, "/pc"},      {45'b0, pcD}, {45'b0, e.pc});
            checkVal({tag, "/pcPlus1"}, {45'b0, pcPlus1D}, {45'b0, e.pcPlus1});
            checkVal({tag, "/count"},   {32'b0, fetchCount}, {32'b0, e.cnt});
        end
    endtask

    task automatic step(input string tag, input bit rn, input bit st, input bit fl,
                        input bit br, input logic [AW-1:0] tg, input bit hl,
                        input bit ev, input logic [AW-1:0] epc,
                        input logic [AW-1:0] epp, input logic [31:0] ecnt);
        drive(rn, st, fl, br, tg, hl, ev, epc, epp, ecnt);
        settle(tag);
    endtask

    task automatic checkWrap(input string tag, input bit ev, input logic [AW-1:0] epc,
                             input logic [AW-1:0] epp);
        checkVal({tag, "/valid"}, {63'b0, validD2}, {63'b0, ev});
        checkVal({tag, "/pc"}, {45'b0, pcD2}, {45'b0, epc});
        checkVal({tag, "/pcPlus1"}, {45'b0, pcPlus1D2}, {45'b0, epp});
        checkVal({tag, "/instr"}, {32'b0, instrD2}, {32'b0, romWord(epc)});
    endtask

    initial begin
        // reset: combinational address shows RESET_PC of each instance
        drive(0, 0, 0, 0, 19'h0, 0, 0, 19'h0, 19'h0, 32'd0);
        checkVal("rstAddr", {45'b0, imemAddr}, 64'h0);
        checkVal("rstAddrWrap", {45'b0, imemAddr2}, 64'h7FFFF);
        settle("rst1");
        step("rst2", 0, 0, 0, 0, 19'h0, 0, 0, 19'h0, 19'h0, 32'd0);
        checkVal("rstWrap/count", {32'b0, fetchCount2}, 64'd0);

        step("boot", 1, 0, 0, 0, 19'h0, 0, 0, 19'h0, 19'h0, 32'd0);
        checkVal("bootWrap/valid", {63'b0, validD2}, 64'd0);
        step("run0", 1, 0, 0, 0, 19'h0, 0, 1, 19'd0, 19'd1, 32'd1);
        checkWrap("wrap0", 1, 19'h7FFFF, 19'h00000);
        step("run1", 1, 0, 0, 0, 19'h0, 0, 1, 19'd1, 19'd2, 32'd2);
        checkVal("imm1", {36'b0, instrImmD}, 64'h0000001);
        checkWrap("wrap1", 1, 19'h00000, 19'h00001);
        step("run2", 1, 0, 0, 0, 19'h0, 0, 1, 19'd2, 19'd3, 32'd3);
        checkWrap("wrap2", 1, 19'h00001, 19'h00002);
        step("run3", 1, 0, 0, 0, 19'h0, 0, 1, 19'd3, 19'd4, 32'd4);
        step("run4", 1, 0, 0, 0, 19'h0, 0, 1, 19'd4, 19'd5, 32'd5);

        for (int i = 0; i < 3; i++)
            step("stall", 1, 1, 0, 0, 19'h0, 0, 1, 19'd4, 19'd5, 32'd5);
        step("afterStall5", 1, 0, 0, 0, 19'h0, 0, 1, 19'd5, 19'd6, 32'd6);
        step("run6", 1, 0, 0, 0, 19'h0, 0, 1, 19'd6, 19'd7, 32'd7);

        step("brStall", 1, 1, 0, 1, 19'h00100, 0, 0, 19'd6, 19'd7, 32'd7);
        step("brTarget", 1, 0, 0, 0, 19'h0, 0, 1, 19'h100, 19'h101, 32'd8);
        step("flush", 1, 0, 1, 0, 19'h0, 0, 0, 19'h100, 19'h101, 32'd8);
        step("afterFlush", 1, 0, 0, 0, 19'h0, 0, 1, 19'h102, 19'h103, 32'd9);
        step("stallFlush", 1, 1, 1, 0, 19'h0, 0, 0, 19'h102, 19'h103, 32'd9);
        step("afterStFl", 1, 0, 0, 0, 19'h0, 0, 1, 19'h103, 19'h104, 32'd10);

        step("br6", 1, 0, 0, 1, 19'd6, 0, 0, 19'h103, 19'h104, 32'd10);
        step("haltBr", 1, 0, 0, 1, 19'd6, 1, 0, 19'h103, 19'h104, 32'd10);
        step("run6b", 1, 0, 0, 0, 19'h0, 0, 1, 19'd6, 19'd7, 32'd11);
        step("run7b", 1, 0, 0, 0, 19'h0, 0, 1, 19'd7, 19'd8, 32'd12);

        drive(1, 0, 0, 0, 19'h0, 1, 1, 19'd8, 19'd9, 32'd13);
        checkVal("haltAddr", {45'b0, imemAddr}, 64'd8);
        settle("haltCycle");
        drive(1, 0, 0, 0, 19'h0, 0, 0, 19'd8, 19'd9, 32'd13);
        checkVal("haltedAddr", {45'b0, imemAddr}, 64'd8);
        settle("halted1");
        drive(1, 0, 0, 1, 19'h50, 0, 0, 19'd8, 19'd9, 32'd13);
        checkVal("haltedBrAddr", {45'b0, imemAddr}, 64'd8);
        settle("haltedBr");
        drive(1, 1, 1, 0, 19'h0, 0, 0, 19'd8, 19'd9, 32'd13);
        checkVal("haltedStAddr", {45'b0, imemAddr}, 64'd8);
        settle("halted2");

        drive(0, 0, 0, 0, 19'h0, 0, 0, 19'h0, 19'h0, 32'd0);
        checkVal("rstAddrHalted", {45'b0, imemAddr}, 64'h0);
        settle("rstHalted");
        step("boot2", 1, 0, 0, 0, 19'h0, 0, 0, 19'h0, 19'h0, 32'd0);
        for (int p = 0; p <= 20; p++)
            step("runLong", 1, 0, 0, 0, 19'h0, 0, 1, AW'(p), AW'(p + 1), 32'(p + 1));

        step("rstMid", 0, 0, 0, 0, 19'h0, 0, 0, 19'h0, 19'h0, 32'd0);
        step("boot3", 1, 0, 0, 0, 19'h0, 0, 0, 19'h0, 19'h0, 32'd0);
        step("restart0", 1, 0, 0, 0, 19'h0, 0, 1, 19'd0, 19'd1, 32'd1);
        step("restart1", 1, 0, 0, 0, 19'h0, 0, 1, 19'd1, 19'd2, 32'd2);

        $display("[TB] %0d tests run, %0d failed", nTests, nFails);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/fetch_stage.md
# fetch_stage

Instruction fetch stage with the IF/ID pipeline register. It holds the PC, drives a synchronous instruction ROM, and presents the fetched instruction to decode. Decode then splits it into control fields, and the `extend` unit receives `Instr[27:0]`. The stage handles stall, flush, branch redirect and halt, and inserts bubbles so decode and `extend` never see wrong-path instructions.

## Interface
Parameters:
- `ADDR_W`, 19, PC / instruction-memory word-address width (matches the `ExtImm` width so branch targets need no resize)
- `INSTR_W`, 32, instruction width
- `RESET_PC`, 0, first fetch address after reset

Ports:
- `clk`  in  1  sole clock, rising edge
- `rst_n`  in  1  reset; synchronous and active-low
- `imem_addr`  out  ADDR_W  ROM read address, equal to the next PC; the ROM registers it, so read data is valid the following cycle
- `imem_rdata`  in  INSTR_W  ROM data for the address presented in the previous cycle
- `stall_d`  in  1  hold PC and IF/ID
- `flush_d`  in  1  load a bubble into IF/ID
- `branch_taken`  in  1  redirect fetch this cycle
- `branch_target`  in  ADDR_W  redirect address
- `halt`  in  1  stop fetching until reset
- `instr_d`  out  INSTR_W  IF/ID instruction; equals NOP (all zeros) when `valid_d` is 0
- `instr_imm_d`  out  28  equals `instr_d[27:0]`; feeds `extend.Instr`
- `pc_d`  out  ADDR_W  PC of `instr_d`
- `pc_plus1_d`  out  ADDR_W  equals `pc_d + 1`, wrapping
- `valid_d`  out  1  IF/ID holds a real instruction
- `fetch_count`  out  32  number of instructions loaded into IF/ID with `valid_d` set

## Operation
- The state machine has three states, encoded by `fetch_state_t`: BOOT, RUN and HALTED.
  - BOOT is entered while `rst_n` is 0 and lasts exactly one cycle after release; it then moves to RUN.
  - RUN moves to HALTED when `halt` is 1 and `branch_taken` is 0.
  - HALTED is left only by reset.
- Internal register `pc_f` is the address whose data is currently on `imem_rdata`.
- Next PC (`imem_addr`), evaluated in priority order:
  1. `rst_n` is 0: `RESET_PC`.
  2. `branch_taken` in RUN: `branch_target`.
  3. `stall_d`, HALTED, or `halt`: `pc_f`.
  4. Otherwise: `pc_f + 1`, modulo 2^ADDR_W, so all-ones wraps to 0.
- IF/ID update at each rising edge, in priority order:
  1. Reset: `valid_d` ← 0, `instr_d` ← 0, `pc_d` ← 0, `fetch_count` ← 0.
  2. `branch_taken`, `flush_d`, BOOT, or HALTED: bubble (`valid_d` ← 0, `instr_d` ← 0); this overrides `stall_d`.
  3. `stall_d`: hold all IF/ID outputs.
  4. Otherwise: load `imem_rdata` and `pc_f`, set `valid_d` ← 1, and increment `fetch_count`, which wraps at 2^32.
- Simultaneous `stall_d` and `flush_d` with no branch: PC holds and IF/ID takes a bubble.
- Simultaneous `branch_taken` and `stall_d`: the redirect wins, the PC loads the target, and IF/ID takes a bubble.
- `halt` and `branch_taken` in the same cycle: the branch is taken and the stage stays in RUN. The halt is ignored unless it is reasserted.
- In HALTED, `imem_addr` holds `pc_f` and the branch, stall and flush inputs are ignored.

## Timing
- All outputs are registered except `imem_addr`, which is combinational from `pc_f` and the control inputs.
- Reset values: all outputs are 0 except `imem_addr`, which is `RESET_PC` while `rst_n` is low.
- Fetch-to-decode latency:
  - an address presented in cycle n appears on `instr_d` at cycle n+2 when there is no stall.
  - the first valid instruction after reset release appears 2 cycles later: one BOOT bubble, then `mem[RESET_PC]`.
- Branch penalty: with `branch_taken` in cycle n, `mem[target]` is valid on `instr_d` at n+2, and `valid_d` is 0 at n+1.
- A stall asserted in cycle n freezes the outputs from n+1 until the cycle after `stall_d` is released.
- Reset asserted mid-operation takes effect at the next edge with no residual state; in-flight instructions are discarded.

## Structure
- Shared package `proc_pkg` holds:
  - `INSTR_W`, `ADDR_W`, `RESET_PC` defaults
  - `NOP_INSTR` (all zeros)
  - the `fetch_state_t` enum (BOOT, RUN, HALTED)
  - `IMM_W` = 28, the width of the `extend` input
- One sub-module, `pc_register`, holds `pc_f` and implements the next-PC priority mux and wrapping increment. The FSM, IF/ID register and counter live in `fetch_stage`.

## Test plan
- Reset then run with `mem[i]` = `0xA0000000 + i`:
  - `valid_d` is 0 for 1 cycle, then `instr_d` = `0xA0000000`, `0xA0000001`, …;
  - `instr_imm_d` = `0x0000001` for `pc_d` = 1;
  - `fetch_count` increments each cycle.
- Assert `stall_d` for 3 cycles while `pc_d` = 4: `instr_d`, `pc_d` and `fetch_count` hold for 3 cycles, then `pc_d` = 5 follows with no skipped or duplicated address.
- Assert `branch_taken` with target `0x00100` while `stall_d` = 1: one bubble, then `pc_d` = `0x00100` and `instr_d` = `mem[0x100]`, with `pc_plus1_d` = `0x00101`.
- Set `RESET_PC` = `0x7FFFF`: `pc_d` sequence is `0x7FFFF`, `0x00000`, `0x00001`; `pc_plus1_d` at `0x7FFFF` is `0x00000`.
- Assert `halt` at `pc_f` = 8, then a branch 2 cycles later: `valid_d` stays 0, `imem_addr` stays 8, `fetch_count` is frozen, and the branch is ignored.
- Assert `rst_n` = 0 for 1 cycle mid-run at `pc_d` = 20: all outputs return to 0 and the fetch sequence restarts from `RESET_PC` with one BOOT bubble.
